// File: rtl/shift_issue.sv
// rtl/shift_issue.sv - decode/issue stage feeding the execute-stage shifter
//
// Accepts decoded MIPS R-type instructions, recognises SLL/SRL/SRA/SLLV/SRLV/SRAV
// and issues shifter operands through a 2-entry skid buffer. Non-shift
// instructions (including the all-zero NOP) are consumed and dropped.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      upstream handshake; instr, rs_data, rt_data payload
//   out_valid/out_ready    downstream handshake to the shifter
//   in_put, N, left, arith shifter operands (value, amount, direction, sign fill)
//   issued_cnt             saturating count of shifts issued downstream
//   dropped_cnt            saturating count of accepted, dropped instructions
module shift_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      in_put,
  output logic [31:0]      N,
  output logic             left,
  output logic             arith,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] dropped_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]  state, state_nxt;
  logic        in_ready_q;

  logic [31:0] main_val, skid_val;
  logic [4:0]  main_amt, skid_amt;
  logic        main_left, skid_left;
  logic        main_arith, skid_arith;

  logic [CNT_W-1:0] issued_q, dropped_q;

  logic        dec_shift;
  logic [4:0]  dec_amt;
  logic        dec_left;
  logic        dec_arith;
  logic        accept, push, drop, pop;

  // Register-field bits and upper rs bits play no part in shift formation.
  logic unused_bits;
  assign unused_bits = ^{instr[25:11], rs_data[31:5]};

  always_comb begin
    dec_shift = 1'b0;
    dec_amt   = instr[10:6];
    dec_left  = 1'b0;
    dec_arith = 1'b0;
    // instr == 0 decodes as "sll $0,$0,0"; it is a NOP and must not issue.
    if (instr[31:26] == 6'd0 && instr != 32'd0) begin
      case (instr[5:0])
        6'b000000: begin dec_shift = 1'b1; dec_left = 1'b1; end
        6'b000010: begin dec_shift = 1'b1; end
        6'b000011: begin dec_shift = 1'b1; dec_arith = 1'b1; end
        6'b000100: begin dec_shift = 1'b1; dec_left = 1'b1; dec_amt = rs_data[4:0]; end
        6'b000110: begin dec_shift = 1'b1; dec_amt = rs_data[4:0]; end
        6'b000111: begin dec_shift = 1'b1; dec_arith = 1'b1; dec_amt = rs_data[4:0]; end
        default:   dec_shift = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready_q;
  assign push   = accept && dec_shift;
  assign drop   = accept && !dec_shift;
  assign pop    = (state != EMPTY) && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !out_ready)      state_nxt = TWO;
        else if (!push && out_ready) state_nxt = EMPTY;
      end
      TWO:     if (out_ready) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_val   <= '0;
      main_amt   <= '0;
      main_left  <= 1'b0;
      main_arith <= 1'b0;
      skid_val   <= '0;
      skid_amt   <= '0;
      skid_left  <= 1'b0;
      skid_arith <= 1'b0;
    end else begin
      state      <= state_nxt;
      // in_ready comes straight from a flop so upstream never sees a comb path.
      in_ready_q <= (state_nxt != TWO);
      if ((state == EMPTY && push) || (state == ONE && push && out_ready)) begin
        main_val   <= rt_data;
        main_amt   <= dec_amt;
        main_left  <= dec_left;
        main_arith <= dec_arith;
      end else if (state == TWO && out_ready) begin
        main_val   <= skid_val;
        main_amt   <= skid_amt;
        main_left  <= skid_left;
        main_arith <= skid_arith;
      end
      if (state == ONE && push && !out_ready) begin
        skid_val   <= rt_data;
        skid_amt   <= dec_amt;
        skid_left  <= dec_left;
        skid_arith <= dec_arith;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_q  <= '0;
      dropped_q <= '0;
    end else begin
      if (pop && issued_q != {CNT_W{1'b1}})  issued_q  <= issued_q + CNT_W'(1);
      if (drop && dropped_q != {CNT_W{1'b1}}) dropped_q <= dropped_q + CNT_W'(1);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state != EMPTY);
  assign in_put      = main_val;
  assign N           = {27'd0, main_amt};
  assign left        = main_left;
  assign arith       = main_arith;
  assign issued_cnt  = issued_q;
  assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_shift_issue.sv
// tb/tb_shift_issue.sv - self-checking bench for shift_issue
module tb_shift_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr, rs_data, rt_data;

  logic        in_ready, out_valid, left, arith;
  logic [31:0] in_put, N;
  logic [15:0] issued_cnt, dropped_cnt;

  logic        s_in_ready, s_out_valid, s_left, s_arith;
  logic [31:0] s_in_put, s_N;
  logic [1:0]  s_issued_cnt, s_dropped_cnt;

  int checks = 0;
  int failures = 0;
  logic [65:0] sb[$];

  always #5 clk = ~clk;

  shift_issue dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready), .in_put(in_put), .N(N),
    .left(left), .arith(arith), .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt)
  );

  shift_issue #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .in_put(s_in_put), .N(s_N),
    .left(s_left), .arith(s_arith), .issued_cnt(s_issued_cnt), .dropped_cnt(s_dropped_cnt)
  );

  function automatic logic [31:0] r_instr(input logic [4:0] rs_i, input logic [4:0] rt_i,
                                          input logic [4:0] sh, input logic [5:0] fn);
    return {6'd0, rs_i, rt_i, 5'd1, sh, fn};
  endfunction

  // Reference decode: {value, amount, left, arith}; returns 1 when the word issues.
  function automatic logic model_dec(input logic [31:0] i, input logic [31:0] rs,
                                     input logic [31:0] rt, output logic [65:0] e);
    logic [31:0] sh_amt, rs_amt;
    sh_amt = {27'd0, i[10:6]};
    rs_amt = {27'd0, rs[4:0]};
    e = '0;
    if (i[31:26] != 6'd0 || i == 32'd0) return 1'b0;
    case (i[5:0])
      6'h00: e = {rt, sh_amt, 1'b1, 1'b0};
      6'h02: e = {rt, sh_amt, 1'b0, 1'b0};
      6'h03: e = {rt, sh_amt, 1'b0, 1'b1};
      6'h04: e = {rt, rs_amt, 1'b1, 1'b0};
      6'h06: e = {rt, rs_amt, 1'b0, 1'b0};
      6'h07: e = {rt, rs_amt, 1'b0, 1'b1};
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven: score any handshake
  // that the next rising edge will perform, then advance one cycle.
  task automatic cycle();
    logic [65:0] e;
    if (out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) chk("unexpected_issue", {65'd0, out_valid}, 66'd0);
      else begin
        e = sb.pop_front();
        chk("issue_data", {in_put, N, left, arith}, e);
      end
    end
    if (in_valid && in_ready === 1'b1) begin
      if (model_dec(instr, rs_data, rt_data, e)) sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1'b1;
    instr    = i;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    rs_data   = '0;
    rt_data   = '0;
    repeat (2) @(negedge clk);

    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_put", in_put, 0);
    chk("rst_N", N, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_dropped", dropped_cnt, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // SLL shamt 5, one-cycle latency.
    send(32'h0000_0140, 32'h0, 32'h1);
    chk("sll_pre_valid", out_valid, 0);
    cycle();
    in_valid = 1'b0;
    chk("sll_valid", out_valid, 1);
    chk("sll_in_put", in_put, 32'h1);
    chk("sll_N", N, 32'd5);
    chk("sll_left", left, 1);
    chk("sll_arith", arith, 0);
    out_ready = 1'b1;
    cycle();

    // SRAV: upper rs bits ignored.
    send(r_instr(5'd1, 5'd2, 5'd0, 6'h07), 32'hFFFF_FFE3, 32'h8000_0000);
    cycle();
    in_valid = 1'b0;
    chk("srav_valid", out_valid, 1);
    chk("srav_N", N, 32'd3);
    chk("srav_dir", {left, arith}, 2'b01);
    cycle();
    chk("issued_after_2", issued_cnt, 2);
    chk("sat_issued_2", s_issued_cnt, 2);

    // Back-pressure: two accepted, third stalls until the shifter drains.
    out_ready = 1'b0;
    send(r_instr(5'd0, 5'd3, 5'd7, 6'h02), 32'h0, 32'hDEAD_BEEF);
    chk("bp_ready_1", in_ready, 1);
    cycle();
    send(r_instr(5'd4, 5'd5, 5'd0, 6'h04), 32'hABCD_EF29, 32'h0000_00F0);
    chk("bp_ready_2", in_ready, 1);
    cycle();
    send(r_instr(5'd0, 5'd6, 5'd31, 6'h03), 32'h0, 32'hF000_0000);
    chk("bp_ready_3", in_ready, 0);
    cycle();
    chk("bp_ready_hold", in_ready, 0);
    chk("bp_hold_data", {in_put, N}, {32'hDEAD_BEEF, 32'd7});
    out_ready = 1'b1;
    cycle();
    chk("bp_ready_back", in_ready, 1);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("bp_issued", issued_cnt, 5);
    chk("sat_issued_stick", s_issued_cnt, 3);
    chk("bp_drained", out_valid, 0);

    // Drops interleaved with shifts, no bubbles at full throughput.
    send(r_instr(5'd0, 5'd1, 5'd2, 6'h00), 32'h0, 32'h0000_0003);
    chk("mix_ready_0", in_ready, 1); cycle();
    send(32'h0000_0000, 32'h0, 32'h5555_5555);
    chk("mix_ready_1", in_ready, 1); cycle();
    send(r_instr(5'd3, 5'd4, 5'd0, 6'h06), 32'h0000_0010, 32'h1234_5678);
    chk("mix_ready_2", in_ready, 1); cycle();
    send(r_instr(5'd1, 5'd2, 5'd0, 6'h20), 32'h1, 32'h2);
    chk("mix_ready_3", in_ready, 1); cycle();
    send(32'h8C22_0004, 32'h1, 32'h2);
    chk("mix_ready_4", in_ready, 1); cycle();
    send(r_instr(5'd1, 5'd2, 5'd0, 6'h20), 32'h3, 32'h4);
    chk("mix_ready_5", in_ready, 1); cycle();
    send(r_instr(5'd0, 5'd7, 5'd1, 6'h03), 32'h0, 32'h8000_0001);
    chk("mix_ready_6", in_ready, 1); cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("mix_dropped", dropped_cnt, 4);
    chk("mix_issued", issued_cnt, 8);
    chk("sat_dropped_stick", s_dropped_cnt, 3);
    chk("mix_sb_empty", sb.size(), 0);

    // Async reset while both entries are occupied.
    out_ready = 1'b0;
    send(r_instr(5'd0, 5'd1, 5'd4, 6'h02), 32'h0, 32'hAAAA_0000);
    cycle();
    send(r_instr(5'd0, 5'd1, 5'd6, 6'h00), 32'h0, 32'h0000_BBBB);
    cycle();
    in_valid = 1'b0;
    chk("two_in_ready", in_ready, 0);
    chk("two_out_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_in_put", in_put, 0);
    chk("async_issued", issued_cnt, 0);
    chk("async_dropped", dropped_cnt, 0);
    sb.delete();
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    instr     = 'x;
    repeat (3) begin
      chk("post_rst_idle", out_valid, 0);
      cycle();
    end
    chk("post_rst_issued", issued_cnt, 0);
    chk("x_instr_no_drop", dropped_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_issue.md
Name: shift_issue

Overview:
- Decode/issue stage directly upstream of the execute-stage shifter (32-bit operand, 32-bit shift amount N, direction flag `left`).
- Accepts decoded MIPS R-type instructions with register operands over a valid/ready handshake.
- Identifies SLL/SRL/SRA/SLLV/SRLV/SRAV and forms shifter operands: value = rt, amount = shamt or rs[4:0], direction, arithmetic flag.
- Outputs are registered through a 2-entry skid buffer. Non-shift instructions are consumed and dropped; issued and dropped events are counted.

Parameters:
CNT_W, 16, width of the issued and dropped event counters (saturating)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents an instruction
in_ready  output  1  stage can accept this cycle
instr  input  32  instruction word
rs_data  input  32  rs register value
rt_data  input  32  rt register value
out_valid  output  1  shift operation available to shifter
out_ready  input  1  shifter consumes this cycle
in_put  output  32  value to shift (rt_data)
N  output  32  shift amount, zero-extended 5-bit
left  output  1  1 = logical left, 0 = right
arith  output  1  1 = arithmetic right (sign fill)
issued_cnt  output  CNT_W  shifts issued downstream
dropped_cnt  output  CNT_W  instructions accepted and dropped

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0; in_put=0; N=0; left=0; arith=0.
  - Both skid entries empty; in_ready=1.
  - issued_cnt=0; dropped_cnt=0.
- Accept: handshake when in_valid and in_ready at a rising edge.
- Decode (instr[31:26]==0 required, else drop):
  - funct 000000 SLL: N=shamt[10:6], left=1, arith=0.
  - funct 000010 SRL: N=shamt, left=0, arith=0.
  - funct 000011 SRA: N=shamt, left=0, arith=1.
  - funct 000100 SLLV: N=rs_data[4:0], left=1.
  - funct 000110 SRLV: N=rs_data[4:0], left=0, arith=0.
  - funct 000111 SRAV: N=rs_data[4:0], left=0, arith=1.
  - N[31:5] is always 0; rs_data[31:5] is ignored.
  - instr==0 (NOP) is dropped, not issued.
  - Any other funct or opcode is dropped.
- Dropped instruction: consumed (in_ready honoured), nothing enters the buffer, dropped_cnt +1.
- Latency: a shift accepted at edge t appears with out_valid=1 after edge t (one cycle). Full throughput of one per cycle while out_ready=1.
- Skid buffer:
  - States: EMPTY, ONE (main reg valid), TWO (main + skid valid).
  - in_ready = (state != TWO), registered.
  - EMPTY + accept shift → ONE.
  - ONE + accept + out_ready → ONE with the new entry.
  - ONE + accept + !out_ready → TWO (new entry in skid).
  - ONE + out_ready, no accept → EMPTY.
  - TWO + out_ready → ONE (skid moves to main).
  - TWO + !out_ready → hold.
  - Order is strictly FIFO; outputs are stable while out_valid && !out_ready.
- Counters:
  - issued_cnt +1 on each out_valid && out_ready.
  - dropped_cnt +1 per dropped accept.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Dropped accept and issue in the same cycle: both counters update.
- Reset mid-operation: the buffer is flushed immediately, pending entries are lost, counters clear.
- Unknown/X on instr while in_valid=0 has no effect.

Test Plan:
- Reset with out_ready=0 → out_valid=0, in_ready=1, counters 0. Release, send SLL instr 0x00000140 (shamt 5), rt=1 → next cycle out_valid=1, in_put=1, N=5, left=1, arith=0.
- SRAV, rs=0xFFFFFFE3, rt=0x80000000 → N=3 (upper rs bits ignored), left=0, arith=1.
- out_ready=0, send 3 back-to-back shifts → first two accepted, in_ready=0 from cycle 3. Raise out_ready → outputs emerge in order, issued_cnt=3.
- Interleave NOP (0x00000000), ADD (funct 100000) and LW (opcode 100011) with shifts → only the shifts appear; dropped_cnt=3; no bubble penalty beyond drop.
- CNT_W=2, issue 5 shifts → issued_cnt sticks at 3.
- Assert reset_n=0 asynchronously while in state TWO → out_valid falls without a clock edge; after release the buffer is empty and no stale entry issues.
